// File: rtl/scanchain_pkg.sv
// scanchain_pkg: opcodes, parser state enum, width defaults and byte-count helpers shared with the scan-chain writer
package scanchain_pkg;
  localparam logic [7:0] OPCODE_WRITE     = 8'h53;
  localparam logic [7:0] OPCODE_WRITE_RST = 8'h52;
  localparam int DEF_ADDR_BITS    = 12;
  localparam int DEF_PAYLOAD_BITS = 160;
  typedef enum logic [2:0] {ST_IDLE, ST_ADDR, ST_PAYLOAD, ST_CHECK, ST_HOLD} state_e;
  function automatic int addr_bytes(input int bits);
    return (bits + 7) / 8;
  endfunction
  function automatic int payload_bytes(input int bits);
    return (bits + 7) / 8;
  endfunction
endpackage

// File: rtl/scanchain_cmd_timeout.sv
// scanchain_cmd_timeout: inter-byte idle counter; clr_i zeroes it, en_i counts, expire_o fires once the count has reached TIMEOUT_CYCLES
//   clk_i, rst_ni : clock, async active-low reset
//   en_i          : parser is inside a frame
//   clr_i         : byte accepted or not inside a frame
//   expire_o      : abort the current frame this cycle
module scanchain_cmd_timeout #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic clr_i,
  output logic expire_o
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q;
  assign expire_o = en_i && cnt_q == CW'(TIMEOUT_CYCLES);
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else cnt_q <= clr_i ? '0 : (en_i && !expire_o) ? cnt_q + 1'b1 : cnt_q;
  end
endmodule

// File: rtl/scanchain_cmd_parser.sv
// scanchain_cmd_parser: assembles opcode/address/payload byte frames into scan-write commands on a valid/ready port
//   clk_i, rst_ni          : clock, async active-low reset
//   rx_data_i/rx_valid_i/rx_ready_o : byte stream from the UART receiver
//   write_*_o/write_ready_i: assembled command handshake to the scan-chain writer
//   frame_error_o          : one-cycle pulse per dropped byte or frame; error_count_o saturates at FF
//   Macro SCANCHAIN_CMD_CHECKSUM_EN adds a trailing XOR check byte to every frame.
module scanchain_cmd_parser
  import scanchain_pkg::*;
#(
  parameter int ADDR_BITS      = DEF_ADDR_BITS,
  parameter int PAYLOAD_BITS   = DEF_PAYLOAD_BITS,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [7:0]              rx_data_i,
  input  logic                    rx_valid_i,
  output logic                    rx_ready_o,
  input  logic                    write_ready_i,
  output logic                    write_valid_o,
  output logic [ADDR_BITS-1:0]    write_addr_o,
  output logic [PAYLOAD_BITS-1:0] write_payload_o,
  output logic                    write_reset_o,
  output logic                    frame_error_o,
  output logic [7:0]              error_count_o
);
  localparam int AB = addr_bytes(ADDR_BITS);
  localparam int PB = payload_bytes(PAYLOAD_BITS);
  localparam int IW = $clog2((AB > PB ? AB : PB) + 1);
  state_e                  state_q;
  logic [IW-1:0]           idx_q;
  logic [ADDR_BITS-1:0]    addr_asm_q, addr_nx, write_addr_q;
  logic [PAYLOAD_BITS-1:0] pay_asm_q, pay_nx, write_payload_q;
  logic                    rst_asm_q, write_valid_q, write_reset_q, frame_error_q;
  logic [7:0]              error_count_q;
  logic accept, expire, in_frame, is_op, last_addr, last_pay, adv, chk_bad, load, err;
`ifdef SCANCHAIN_CMD_CHECKSUM_EN
  logic [7:0] xor_q;
  assign chk_bad = state_q == ST_CHECK && rx_data_i != xor_q;
  assign load    = accept && !expire && state_q == ST_CHECK && !chk_bad;
`else
  assign chk_bad = 1'b0;
  assign load    = accept && !expire && state_q == ST_PAYLOAD && last_pay;
`endif
  assign rx_ready_o      = state_q != ST_HOLD;
  assign accept          = rx_valid_i && rx_ready_o;
  assign in_frame        = state_q inside {ST_ADDR, ST_PAYLOAD, ST_CHECK};
  assign is_op           = rx_data_i == OPCODE_WRITE || rx_data_i == OPCODE_WRITE_RST;
  assign last_addr       = idx_q == IW'(AB - 1);
  assign last_pay        = idx_q == IW'(PB - 1);
  assign adv             = accept && ((state_q == ST_ADDR && !last_addr) || (state_q == ST_PAYLOAD && !last_pay));
  assign err             = expire || (accept && ((state_q == ST_IDLE && !is_op) || chk_bad));
  assign write_valid_o   = write_valid_q;
  assign write_addr_o    = write_addr_q;
  assign write_payload_o = write_payload_q;
  assign write_reset_o   = write_reset_q;
  assign frame_error_o   = frame_error_q;
  assign error_count_o   = error_count_q;
  scanchain_cmd_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .en_i     (in_frame),
    .clr_i    (accept || !in_frame),
    .expire_o (expire)
  );
  // Byte k lands on bits [8k+7:8k]; bits past the field width simply have no home.
  always_comb begin
    addr_nx = addr_asm_q;
    pay_nx  = pay_asm_q;
    for (int b = 0; b < ADDR_BITS; b++)
      if (accept && state_q == ST_ADDR && b / 8 == int'(idx_q)) addr_nx[b] = rx_data_i[b % 8];
    for (int b = 0; b < PAYLOAD_BITS; b++)
      if (accept && state_q == ST_PAYLOAD && b / 8 == int'(idx_q)) pay_nx[b] = rx_data_i[b % 8];
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= ST_IDLE;
      idx_q           <= '0;
      addr_asm_q      <= '0;
      pay_asm_q       <= '0;
      rst_asm_q       <= 1'b0;
      write_valid_q   <= 1'b0;
      write_addr_q    <= '0;
      write_payload_q <= '0;
      write_reset_q   <= 1'b0;
      frame_error_q   <= 1'b0;
      error_count_q   <= '0;
`ifdef SCANCHAIN_CMD_CHECKSUM_EN
      xor_q           <= '0;
`endif
    end else begin
      frame_error_q <= err;
      error_count_q <= error_count_q + ((err && error_count_q != 8'hFF) ? 8'd1 : 8'd0);
      addr_asm_q    <= addr_nx;
      pay_asm_q     <= pay_nx;
      idx_q         <= (adv && !expire) ? idx_q + 1'b1 : (accept || expire) ? '0 : idx_q;
      write_valid_q <= load || (write_valid_q && !write_ready_i);
`ifdef SCANCHAIN_CMD_CHECKSUM_EN
      if (accept) xor_q <= state_q == ST_IDLE ? rx_data_i : xor_q ^ rx_data_i;
`endif
      if (load) begin
        write_addr_q    <= addr_asm_q;
        write_payload_q <= pay_nx;
        write_reset_q   <= rst_asm_q;
      end
      if (state_q == ST_IDLE && accept && is_op) rst_asm_q <= rx_data_i == OPCODE_WRITE_RST;
      // A byte arriving in the expiry cycle is swallowed: the frame is abandoned first.
      if (expire) state_q <= ST_IDLE;
      else
        case (state_q)
          ST_IDLE:    if (accept && is_op) state_q <= ST_ADDR;
          ST_ADDR:    if (accept && last_addr) state_q <= ST_PAYLOAD;
`ifdef SCANCHAIN_CMD_CHECKSUM_EN
          ST_PAYLOAD: if (accept && last_pay) state_q <= ST_CHECK;
          ST_CHECK:   if (accept) state_q <= chk_bad ? ST_IDLE : ST_HOLD;
`else
          ST_PAYLOAD: if (accept && last_pay) state_q <= ST_HOLD;
`endif
          ST_HOLD:    if (write_ready_i) state_q <= ST_IDLE;
          default:    state_q <= ST_IDLE;
        endcase
    end
  end
endmodule

// File: tb/tb_scanchain_cmd_parser.sv
// tb_scanchain_cmd_parser: directed plus randomized frames checked against a byte-level frame model
module tb_scanchain_cmd_parser;
  localparam int TO = 100;
  logic         clk = 1'b0, rst_n = 1'b0, rx_valid = 1'b0, write_ready = 1'b0;
  logic [7:0]   rx_data = 8'h00;
  logic         rx_ready, write_valid, write_reset, frame_error;
  logic [11:0]  write_addr;
  logic [159:0] write_payload;
  logic [7:0]   error_count;
  int total = 0, passed = 0, fails = 0, exp_err = 0;
  logic [7:0] fr_op;
  logic [7:0] fr_a [2];
  logic [7:0] fr_p [20];
  logic ok;

  always #5 clk = ~clk;

  scanchain_cmd_parser #(.ADDR_BITS(12), .PAYLOAD_BITS(160), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .rx_data_i       (rx_data),
    .rx_valid_i      (rx_valid),
    .rx_ready_o      (rx_ready),
    .write_ready_i   (write_ready),
    .write_valid_o   (write_valid),
    .write_addr_o    (write_addr),
    .write_payload_o (write_payload),
    .write_reset_o   (write_reset),
    .frame_error_o   (frame_error),
    .error_count_o   (error_count)
  );

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
  endtask

  function automatic logic [7:0] junk_byte();
    logic [7:0] b = 8'($urandom);
    return (b == 8'h52 || b == 8'h53) ? 8'h7F : b;
  endfunction

  function automatic logic [7:0] frame_xor();
    logic [7:0] x = fr_op ^ fr_a[0] ^ fr_a[1];
    for (int i = 0; i < 20; i++) x ^= fr_p[i];
    return x;
  endfunction

  task automatic rand_frame();
    fr_op = $urandom_range(1) ? 8'h52 : 8'h53;
    for (int i = 0; i < 2; i++) fr_a[i] = 8'($urandom);
    for (int i = 0; i < 20; i++) fr_p[i] = 8'($urandom);
  endtask

  task automatic send_body();
    send_byte(fr_op);
    for (int i = 0; i < 2; i++) send_byte(fr_a[i]);
    for (int i = 0; i < 20; i++) send_byte(fr_p[i]);
  endtask

  task automatic send_frame();
    send_body();
`ifdef SCANCHAIN_CMD_CHECKSUM_EN
    send_byte(frame_xor());
`endif
  endtask

  task automatic bad_byte();
    send_byte(junk_byte());
    exp_err = exp_err < 255 ? exp_err + 1 : 255;
  endtask

  // Checks the command presented for the current frame, stalls it, then completes the handshake.
  task automatic expect_write(input string tag, input int stall);
    logic [11:0]  ea = 12'((int'(fr_a[1]) << 8) | int'(fr_a[0]));
    logic [159:0] ep = '0;
    for (int i = 0; i < 20; i++) ep |= 160'(fr_p[i]) << (8 * i);
    chk({tag, "_valid"}, 160'(write_valid), 160'(1));
    chk({tag, "_addr"}, 160'(write_addr), 160'(ea));
    chk({tag, "_payload"}, write_payload, ep);
    chk({tag, "_reset"}, 160'(write_reset), 160'(fr_op == 8'h52));
    ok = 1'b1;
    for (int i = 0; i < stall; i++) begin
      rx_data  = 8'($urandom);
      rx_valid = 1'b1;
      step();
      if (write_valid !== 1'b1 || write_addr !== ea || write_payload !== ep || rx_ready !== 1'b0) ok = 1'b0;
    end
    rx_valid = 1'b0;
    chk({tag, "_hold_stable"}, 160'(ok), 160'(1));
    write_ready = 1'b1;
    step();
    write_ready = 1'b0;
    chk({tag, "_done_valid"}, 160'(write_valid), 160'(0));
    chk({tag, "_done_ready"}, 160'(rx_ready), 160'(1));
    chk({tag, "_errcnt"}, 160'(error_count), 160'(exp_err));
  endtask

  initial begin
    #3;
    chk("rst_valid", 160'(write_valid), 160'(0));
    chk("rst_errcnt", 160'(error_count), 160'(0));
    chk("rst_ferr", 160'(frame_error), 160'(0));
    chk("rst_ready", 160'(rx_ready), 160'(1));
    step();
    step();
    rst_n = 1'b1;
    step();

    fr_op = 8'h53; fr_a[0] = 8'h34; fr_a[1] = 8'h12;
    for (int i = 0; i < 20; i++) fr_p[i] = 8'(i + 1);
    send_frame();
    expect_write("t1", 2);

    fr_op = 8'h52;
    send_frame();
    expect_write("t2", 50);

    send_byte(8'h7F);
    exp_err++;
    chk("t3_ferr", 160'(frame_error), 160'(1));
    chk("t3_errcnt", 160'(error_count), 160'(1));
    step();
    chk("t3_ferr_pulse", 160'(frame_error), 160'(0));
    rand_frame();
    send_frame();
    expect_write("t3", 3);

    send_byte(8'h53);
    send_byte(8'h34);
    ok = 1'b1;
    for (int i = 0; i < TO; i++) begin
      step();
      if (frame_error !== 1'b0 || write_valid !== 1'b0) ok = 1'b0;
    end
    chk("t4_no_early_abort", 160'(ok), 160'(1));
    send_byte(8'h53);
    exp_err++;
    chk("t4_ferr", 160'(frame_error), 160'(1));
    chk("t4_valid", 160'(write_valid), 160'(0));
    chk("t4_errcnt", 160'(error_count), 160'(exp_err));
    rand_frame();
    send_frame();
    expect_write("t4", 1);

    for (int n = 0; n < 8; n++) begin
      if ($urandom_range(2) == 0) begin
        bad_byte();
        chk("rnd_junk_ferr", 160'(frame_error), 160'(1));
      end
      rand_frame();
      send_frame();
      expect_write("rnd", int'($urandom_range(0, 5)));
    end

`ifdef SCANCHAIN_CMD_CHECKSUM_EN
    rand_frame();
    send_body();
    send_byte(frame_xor() ^ 8'h01);
    exp_err++;
    chk("t5_bad_ferr", 160'(frame_error), 160'(1));
    chk("t5_bad_valid", 160'(write_valid), 160'(0));
    step();
    chk("t5_bad_valid2", 160'(write_valid), 160'(0));
    rand_frame();
    send_frame();
    expect_write("t5", 2);
`endif

    for (int i = 0; i < 256; i++) bad_byte();
    chk("t6_saturate", 160'(error_count), 160'(8'hFF));
    chk("t6_model", 160'(exp_err), 160'(255));
    rand_frame();
    send_byte(fr_op);
    send_byte(fr_a[0]);
    send_byte(fr_a[1]);
    for (int i = 0; i < 5; i++) send_byte(fr_p[i]);
    #2 rst_n = 1'b0;
    #1;
    exp_err = 0;
    chk("t6_rst_errcnt", 160'(error_count), 160'(0));
    chk("t6_rst_valid", 160'(write_valid), 160'(0));
    chk("t6_rst_addr", 160'(write_addr), 160'(0));
    chk("t6_rst_payload", write_payload, 160'(0));
    chk("t6_rst_ready", 160'(rx_ready), 160'(1));
    step();
    rst_n = 1'b1;
    step();
    rand_frame();
    send_frame();
    expect_write("t6", 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
